// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM request front end.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ISSUED = 2'd1,
    RD_DATA   = 2'd2,
    HOLD      = 2'd3
  } state_e;

  // Request layout at the default widths; the FIFO stores {wr, addr, wdata} in this order.
  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_req_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter.
// Pushes when full and pops when empty are ignored, so the count never wraps.
module ram_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// In-order request front end for a single-port synchronous RAM.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_wr,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_wdata,
  input  logic [DATA_WIDTH-1:0]           ram_rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic [REQ_W-1:0]      head;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;
  state_e                state_q;
  state_e                state_d;

  assign {head_wr, head_addr, head_wdata} = head;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  // Writes may slip past an outstanding read; a read only leaves the head when no read is in flight.
  assign issue     = !fifo_empty && (head_wr || (state_q == IDLE));
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign dbg_state = state_q;

  ram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_wr, req_addr, req_wdata}),
    .pop   (issue),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (issue) begin
      ram_en    <= 1'b1;
      ram_we    <= head_wr;
      ram_addr  <= head_addr;
      ram_wdata <= head_wdata;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue && !head_wr) state_d = RD_ISSUED;
      RD_ISSUED: state_d = RD_DATA;
      RD_DATA:   state_d = HOLD;
      HOLD:      if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // RD_DATA is the cycle in which the RAM presents the read; HOLD keeps the captured word stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_DATA) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= ram_rdata;
      end else if ((state_q == HOLD) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: transaction-level scoreboard on every cycle plus directed timing checks.
module tb_ram_req_ctrl;
  import ram_ctrl_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic [1:0]    dbg_state;

  ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_count(fifo_count), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM environment ----------------
  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [16:0]   exp_q[$];        // requests in program order, not yet seen on the RAM port
  logic [DW-1:0] rsp_q[$];        // read data owed to the consumer, in order
  logic [DW-1:0] got_q[$];        // read data actually accepted
  logic [DW-1:0] shadow [256];    // memory contents implied by program order
  req_t          e_req;
  int            cnt_m;
  logic          rd_out;
  int            rd_age;
  logic          prev_valid;
  logic          prev_hs;
  logic [DW-1:0] prev_data;
  int            max_cnt;
  int            run;
  int            max_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rsp_q.delete();
      cnt_m      = 0;
      rd_out     = 1'b0;
      rd_age     = 0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (rd_out) rd_age++;
      if (ram_en) begin
        if (exp_q.size() == 0) begin
          check("ram_unexpected_issue", 32'(ram_en), 32'd0);
        end else begin
          e_req = exp_q.pop_front();
          cnt_m--;
          check("ram_we_order", 32'(ram_we), 32'(e_req.wr));
          check("ram_addr_order", 32'(ram_addr), 32'(e_req.addr));
          if (e_req.wr) begin
            check("ram_wdata_order", 32'(ram_wdata), 32'(e_req.wdata));
            shadow[e_req.addr] = e_req.wdata;
          end else begin
            check("read_while_read_out", 32'(rd_out), 32'd0);
            rsp_q.push_back(shadow[e_req.addr]);
            rd_out = 1'b1;
            rd_age = 0;
          end
        end
      end else begin
        check("ram_we_without_en", 32'(ram_we), 32'd0);
      end
      check("fifo_count", 32'(fifo_count), 32'(cnt_m));
      check("req_ready", 32'(req_ready), 32'(cnt_m != DEPTH));
      check("busy", 32'(busy), 32'((cnt_m != 0) || rd_out));
      // A read shows on rsp two edges after it appears on the RAM port.
      check("rsp_valid_timing", 32'(rsp_valid), 32'(rd_out && (rd_age >= 2)));
      if (prev_valid && !prev_hs)
        check("rsp_rdata_stable", 32'(rsp_rdata), 32'(prev_data));
      prev_valid = rsp_valid;
      prev_data  = rsp_rdata;
      prev_hs    = rsp_valid && rsp_ready;
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
        end
        got_q.push_back(rsp_rdata);
        rd_out = 1'b0;
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({req_wr, req_addr, req_wdata});
        cnt_m++;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (ram_we) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("send_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(busy || rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold();
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != 2'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_hold_timeout", 32'(dbg_state), 32'd3);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] got(input int i);
    return (got_q.size() > i) ? 32'(got_q[i]) : 32'hdead_beef;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    max_cnt   = 0;
    run       = 0;
    max_run   = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end

    #1 rst_n = 1'b0;
    #11;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Write then read: write visible one cycle after accept, read data three cycles after.
    @(posedge clk);
    #1;
    send(1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    check("wr_lat0_ram_en", 32'(ram_en), 32'd0);
    check("wr_lat0_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check("wr_lat1_ram_we", 32'(ram_we), 32'd1);
    check("wr_lat1_addr", 32'(ram_addr), 32'h10);
    check("wr_lat1_wdata", 32'(ram_wdata), 32'hA5);
    @(posedge clk);
    #1;
    send(1'b0, 8'h10, 8'h00);
    repeat (2) @(negedge clk);
    check("rd_issue_en", 32'(ram_en), 32'd1);
    check("rd_issue_we", 32'(ram_we), 32'd0);
    check("rd_issue_addr", 32'(ram_addr), 32'h10);
    @(negedge clk);
    check("rd_lat2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_lat3_valid", 32'(rsp_valid), 32'd1);
    check("rd_lat3_rdata", 32'(rsp_rdata), 32'hA5);
    @(negedge clk);
    check("rd_lat4_valid", 32'(rsp_valid), 32'd0);

    // Back-to-back writes: one issue per cycle, the FIFO never holds more than one.
    @(posedge clk);
    #1;
    max_cnt = 0;
    max_run = 0;
    run     = 0;
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(i + 1));
    repeat (4) @(negedge clk);
    check("b2b_we_run", 32'(max_run), 32'd4);
    check("b2b_max_count", 32'(max_cnt), 32'd1);
    check("b2b_mem3", 32'(mem[3]), 32'h04);

    // Ordering: reads see exactly the writes that precede them.
    @(posedge clk);
    #1;
    got_q.delete();
    send(1'b1, 8'd3, 8'h11);
    send(1'b0, 8'd3, 8'h00);
    send(1'b1, 8'd3, 8'h22);
    send(1'b0, 8'd3, 8'h00);
    wait_idle();
    check("ord_count", 32'(got_q.size()), 32'd2);
    check("ord_rsp0", got(0), 32'h11);
    check("ord_rsp1", got(1), 32'h22);

    // Full/backpressure: a read parked in HOLD blocks the next read and everything behind it.
    rsp_ready = 1'b0;
    got_q.delete();
    send(1'b0, 8'd0, 8'h00);
    wait_hold();
    send(1'b0, 8'd1, 8'h00);
    send(1'b1, 8'd4, 8'h31);
    send(1'b1, 8'd5, 8'h32);
    send(1'b1, 8'd6, 8'h33);
    @(negedge clk);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_hold_rdata", 32'(rsp_rdata), 32'h01);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(1'b1, 8'd7, 8'h34);
    wait_idle();
    check("drain_rsp0", got(0), 32'h01);
    check("drain_rsp1", got(1), 32'h02);
    check("drain_mem6", 32'(mem[6]), 32'h33);
    check("drain_mem7", 32'(mem[7]), 32'h34);

    // Reset mid-operation: HOLD with two requests queued.
    rsp_ready = 1'b0;
    send(1'b0, 8'd2, 8'h00);
    wait_hold();
    send(1'b0, 8'd3, 8'h00);
    send(1'b1, 8'd9, 8'h99);
    @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_ram_en", 32'(ram_en), 32'd0);
    end
    check("post_rst_mem9", 32'(mem[9]), 32'd0);
    @(posedge clk);
    #1;
    got_q.delete();
    send(1'b1, 8'd9, 8'h77);
    send(1'b0, 8'd9, 8'h00);
    wait_idle();
    check("post_rst_rsp", got(0), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
